c3lib_ckmux4_sel_ctrl: RTL and testbench

C3LIB_CKMUX4_SEL_CTRL -- requirements
Module: c3lib_ckmux4_sel_ctrl

---
 rtl/c3lib_ckmux4_sel_ctrl.sv | 138 +++++++++++++
 tb/tb_c3lib_ckmux4_sel_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/c3lib_ckmux4_sel_ctrl.sv
// c3lib_ckmux4_sel_ctrl: sequences a 4:1 clock-mux select change behind a gated ck_en window.
// Optional test override of the selects is enabled by defining C3LIB_CKMUX4_SEL_TST_EN.
module c3lib_ckmux4_sel_ctrl #(
  parameter int unsigned GATE_WAIT   = 4,
  parameter int unsigned SETTLE_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_sel,
`ifdef C3LIB_CKMUX4_SEL_TST_EN
  input  logic       tst_override,
  input  logic       tst_s0,
  input  logic       tst_s1,
`endif
  output logic       req_ready,
  output logic       s0,
  output logic       s1,
  output logic       ck_en,
  output logic       done,
  output logic       busy
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_WAIT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_OFF = 2'd1,
    SETTLE   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         tgt_q, tgt_d;
  logic               ck_en_q, ck_en_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               freeze_c;
  logic               accept_c;

  assign accept_c = req_valid & req_ready;

  // State and output registers; reset forces the safe select 00 with the clock enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 2'b00;
      tgt_q   <= 2'b00;
      ck_en_q <= 1'b1;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      ck_en_q <= ck_en_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: gate the clock, switch the select mid-window, then re-enable.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    tgt_d   = tgt_q;
    ck_en_d = ck_en_q;
    done_d  = 1'b0;
    if (!freeze_c) begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            if (req_sel == sel_q) begin
              done_d = 1'b1;
            end else begin
              tgt_d   = req_sel;
              ck_en_d = 1'b0;
              cnt_d   = GATE_LOAD;
              state_d = GATE_OFF;
            end
          end
        end
        GATE_OFF: begin
          if (cnt_q == '0) begin
            sel_d   = tgt_q;
            cnt_d   = SETTLE_LOAD;
            state_d = SETTLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            ck_en_d = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          ck_en_d = 1'b1;
        end
      endcase
    end
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

`ifdef C3LIB_CKMUX4_SEL_TST_EN
  // Test override takes the mux pins directly and holds the FSM frozen.
  assign freeze_c  = tst_override;
  assign s0        = tst_override ? tst_s0 : sel_q[0];
  assign s1        = tst_override ? tst_s1 : sel_q[1];
  assign ck_en     = tst_override | ck_en_q;
  assign req_ready = ~tst_override & ready_q;
  assign done      = ~tst_override & done_q;
`else
  assign freeze_c  = 1'b0;
  assign s0        = sel_q[0];
  assign s1        = sel_q[1];
  assign ck_en     = ck_en_q;
  assign req_ready = ready_q;
  assign done      = done_q;
`endif
  assign busy = busy_q;

endmodule

// File: tb/tb_c3lib_ckmux4_sel_ctrl.sv
// Testbench for c3lib_ckmux4_sel_ctrl (GATE_WAIT=4, SETTLE_WAIT=3) with an elapsed-cycle reference model.
module tb_c3lib_ckmux4_sel_ctrl;

  localparam int G = 4;
  localparam int S = 3;
  localparam int L = G + S + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready, s0, s1, ck_en, done, busy;
`ifdef C3LIB_CKMUX4_SEL_TST_EN
  logic       tst_override, tst_s0, tst_s1;
`endif

  c3lib_ckmux4_sel_ctrl #(.GATE_WAIT(G), .SETTLE_WAIT(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_sel   (req_sel),
`ifdef C3LIB_CKMUX4_SEL_TST_EN
    .tst_override (tst_override),
    .tst_s0       (tst_s0),
    .tst_s1       (tst_s1),
`endif
    .req_ready (req_ready),
    .s0        (s0),
    .s1        (s1),
    .ck_en     (ck_en),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a switch is described by its acceptance cycle; outputs follow from elapsed cycles.
  int         cyc = 0;
  int         acc_cyc = 0;
  int         done_cyc = -1;
  bit         sw_on = 1'b0;
  logic [1:0] cur = 2'b00;
  logic [1:0] old_s = 2'b00;
  logic [1:0] tgt = 2'b00;
  logic [5:0] exp_o = 6'b000100;
  bit         tb_ovr = 1'b0;
  logic [1:0] tb_ts = 2'b00;

  function automatic void model_edge(input bit r, input bit v, input logic [1:0] s);
    int k;
    cyc++;
    if (!r) begin
      sw_on = 1'b0; cur = 2'b00; done_cyc = -1; exp_o = 6'b0_00_1_0_0;
      return;
    end
    if (tb_ovr) begin
      if (sw_on) acc_cyc++;
      done_cyc = -1;
      exp_o = {1'b0, tb_ts, 1'b1, 1'b0, sw_on};
      return;
    end
    if (v && exp_o[5]) begin
      if (s == cur) done_cyc = cyc;
      else begin sw_on = 1'b1; acc_cyc = cyc - 1; old_s = cur; tgt = s; end
    end
    if (sw_on) begin
      k = cyc - acc_cyc;
      if (k >= L) begin
        sw_on = 1'b0; cur = tgt;
        exp_o = {1'b1, tgt, 1'b1, 1'b1, 1'b0};
      end else begin
        exp_o = {1'b0, (k > G) ? tgt : old_s, 1'b0, 1'b0, 1'b1};
      end
    end else begin
      exp_o = {1'b1, cur, 1'b1, (done_cyc == cyc), 1'b0};
    end
  endfunction

  function automatic logic [5:0] sample();
    return {req_ready, s1, s0, ck_en, done, busy};
  endfunction

  task automatic tick(input bit r, input bit v, input logic [1:0] s);
    rst_n = r; req_valid = v; req_sel = s;
    @(posedge clk);
    model_edge(r, v, s);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 2'd0);
      obs = sample();
      n_vec++;
      if (obs !== 6'b0_00_1_0_0) begin
        n_err++; $display("FAIL reset_vals cyc=%0d got=%b exp=%b", cyc, obs, 6'b000100);
      end
    end
    tick(1'b1, 1'b0, 2'd0);
    obs = sample();
    n_vec++;
    if (obs !== 6'b1_00_1_0_0) begin
      n_err++; $display("FAIL reset_release cyc=%0d got=%b exp=%b", cyc, obs, 6'b100100);
    end
    n_vec++;
    if (obs !== exp_o) begin
      n_err++; $display("FAIL reset_model cyc=%0d got=%b exp=%b", cyc, obs, exp_o);
    end
  endtask

  task automatic test_switch();
    logic [5:0] obs;
    int lows = 0, dones = 0, sel_at5 = -1;
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, i == 1, 2'd2);
      obs = sample();
      if (!ck_en) lows++;
      if (done) dones++;
      if (i == 5) sel_at5 = int'({s1, s0});
      n_vec++;
      if (obs !== exp_o) begin
        n_err++; $display("FAIL switch cyc=%0d k=%0d got=%b exp=%b", cyc, i, obs, exp_o);
      end
    end
    n_vec++;
    if (lows !== 7 || dones !== 1) begin
      n_err++; $display("FAIL switch_window lows=%0d dones=%0d exp 7/1", lows, dones);
    end
    n_vec++;
    if (sel_at5 !== 2) begin
      n_err++; $display("FAIL switch_sel_at5 got=%0d exp=2", sel_at5);
    end
  endtask

  task automatic test_same_sel();
    logic [5:0] obs;
    for (int i = 1; i <= 3; i++) begin
      tick(1'b1, i == 1, cur);
      obs = sample();
      n_vec++;
      if (obs !== exp_o || busy !== 1'b0 || ck_en !== 1'b1) begin
        n_err++; $display("FAIL same_sel cyc=%0d got=%b exp=%b", cyc, obs, exp_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] obs;
    int dones = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(i != 4, i == 1, 2'd3);
      obs = sample();
      if (done) dones++;
      n_vec++;
      if (obs !== exp_o) begin
        n_err++; $display("FAIL reset_mid cyc=%0d step=%0d got=%b exp=%b", cyc, i, obs, exp_o);
      end
    end
    n_vec++;
    if (dones !== 0) begin
      n_err++; $display("FAIL reset_mid_done got=%0d exp=0", dones);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] obs;
    int d_first = -1, d_second = -1, dones = 0;
    tick(1'b1, 1'b1, 2'd2);
    for (int i = 2; i <= 18; i++) begin
      tick(1'b1, i <= 9, 2'd1);
      obs = sample();
      if (done) begin
        dones++;
        if (d_first < 0) d_first = i; else d_second = i;
      end
      n_vec++;
      if (obs !== exp_o) begin
        n_err++; $display("FAIL back_to_back cyc=%0d step=%0d got=%b exp=%b", cyc, i, obs, exp_o);
      end
    end
    n_vec++;
    if (dones !== 2 || d_second - d_first !== 8 || {s1, s0} !== 2'd1) begin
      n_err++; $display("FAIL b2b_timing dones=%0d gap=%0d sel=%0d exp 2/8/1", dones, d_second - d_first, {s1, s0});
    end
  endtask

  task automatic test_random();
    logic [5:0] obs;
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 39) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      obs = sample();
      n_vec++;
      if (obs !== exp_o) begin
        n_err++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, exp_o);
      end
    end
  endtask

`ifdef C3LIB_CKMUX4_SEL_TST_EN
  task automatic test_override();
    logic [5:0] obs;
    logic [1:0] s;
    int dones = 0;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 2'd0);
    s = cur ^ 2'b01;
    for (int i = 1; i <= 16; i++) begin
      tb_ovr = (i >= 4 && i <= 6);
      tb_ts = 2'b11;
      tst_override = tb_ovr; tst_s0 = 1'b1; tst_s1 = 1'b1;
      tick(1'b1, i == 1, s);
      obs = sample();
      if (done) dones++;
      n_vec++;
      if (obs !== exp_o) begin
        n_err++; $display("FAIL override cyc=%0d step=%0d got=%b exp=%b", cyc, i, obs, exp_o);
      end
    end
    n_vec++;
    if (dones !== 1 || {s1, s0} !== s) begin
      n_err++; $display("FAIL override_resume dones=%0d sel=%0d exp 1/%0d", dones, {s1, s0}, s);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_sel = 2'd0;
`ifdef C3LIB_CKMUX4_SEL_TST_EN
    tst_override = 1'b0; tst_s0 = 1'b0; tst_s1 = 1'b0;
`endif
    test_reset();
    test_switch();
    test_same_sel();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef C3LIB_CKMUX4_SEL_TST_EN
    test_override();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
